fir_mem_stream_reader: RTL

Streaming reader that drains a block of 64-bit words from port 2 (s2) of the FIR dual-port sample memory and presents them as a 16-bit Avalon-ST sample stream. It sits directly downstream of the FIR memory and feeds the FIR datapath. Software or a control FSM fills the memory through port 1 and then starts this block with a base address and word count. Each word is unpacked into four samples, lane 0 (bits 15:0) first.

---
 rtl/fir_mem_stream_reader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fir_mem_stream_reader.sv
// fir_mem_stream_reader
//    Drains a block of 64-bit words from port 2 of the FIR sample memory and
//    emits them as a 16-bit Avalon-ST sample stream. Lane 0 (bits 15:0) goes first.
//
// Ports
//    clk, reset_n            clock; synchronous active-low reset
//    start, abort            one-cycle start pulse (IDLE only); level abort (RUN/DRAIN)
//    base_addr, length       first word address and word count, captured on start
//    busy, done              not-IDLE flag; one-cycle completion pulse
//    mem_*                   memory port 2 (address registered in the memory, data not)
//    out_data/valid/ready    sample stream
//    out_sop, out_eop        first / last sample of the block
//    stall_cnt               cycles with out_valid & !out_ready (FIR_STREAM_STALL_CNT_EN only)
//
// Optional feature macro: FIR_STREAM_STALL_CNT_EN
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, streaming samples
// DRAIN | all reads issued, emptying the word buffer
// DONE  | one-cycle completion pulse
module fir_mem_stream_reader #(
   parameter int BASE_W     = 14,
   parameter int LEN_W      = 15,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [BASE_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [BASE_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [7:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [63:0]       mem_readdata,
   output logic [15:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop
`ifdef FIR_STREAM_STALL_CNT_EN
   ,output logic [31:0]      stall_cnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [BASE_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [LEN_W-1:0]  words_q, words_d;
   logic [1:0]        lane_q, lane_d;
   logic              inflight_q, inflight_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [63:0]       fifo_q [FIFO_DEPTH];
   logic [63:0]       fifo_d [FIFO_DEPTH];

   logic        hs, pop, push, issue, abort_act, last_word, final_hs;
   logic [63:0] head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Reads in flight count against the buffer so a returning word always has a slot.
   assign issue     = (state_q == S_RUN) && !abort &&
                      ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH);
   assign out_valid = (count_q != '0);
   assign hs        = out_valid && out_ready;
   assign pop       = hs && (lane_q == 2'd3);
   assign push      = inflight_q;
   assign abort_act = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
   assign last_word = (words_q == (len_q - LEN_W'(1)));
   assign final_hs  = pop && last_word;
   assign head      = fifo_q[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      issued_d   = issued_q;
      words_d    = words_q;
      lane_d     = lane_q;
      inflight_d = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      fifo_d     = fifo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               len_d    = length;
               issued_d = '0;
               words_d  = '0;
               lane_d   = 2'd0;
               state_d  = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (issue && ((issued_q + LEN_W'(1)) == len_q)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (final_hs) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         addr_d     = addr_q + BASE_W'(1);
         issued_d   = issued_q + LEN_W'(1);
         inflight_d = 1'b1;
      end
      if (push) begin
         fifo_d[wr_ptr_q] = mem_readdata;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (hs) lane_d = lane_q + 2'd1;
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         words_d  = words_q + LEN_W'(1);
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      // Abort takes priority over everything, including a coincident final handshake.
      if (abort_act) begin
         state_d    = S_IDLE;
         inflight_d = 1'b0;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         lane_d     = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         words_q    <= '0;
         lane_q     <= 2'd0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         words_q    <= words_d;
         lane_q     <= lane_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         fifo_q     <= fifo_d;
      end
   end

   always_comb begin
      out_data = 16'h0000;
      if (out_valid) begin
         case (lane_q)
            2'd0:    out_data = head[15:0];
            2'd1:    out_data = head[31:16];
            2'd2:    out_data = head[47:32];
            default: out_data = head[63:48];
         endcase
      end
   end

   assign out_sop        = out_valid && (lane_q == 2'd0) && (words_q == '0);
   assign out_eop        = out_valid && (lane_q == 2'd3) && last_word;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign mem_address    = addr_q;
   assign mem_chipselect = issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 8'hFF;
   assign mem_clken      = 1'b1;

`ifdef FIR_STREAM_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_IDLE) && start)
         stall_cnt_d = '0;
      else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) stall_cnt_q <= '0;
      else          stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
